// File: rtl/fir_out_pkg.sv
// Shared constants and helpers for the FIR output decimator.
// Build option FIR_OUT_SAT_EN selects clamping instead of wrap when narrowing.
package fir_out_pkg;

  localparam int FIR_WL  = 32;
  localparam int FIR_OWL = 16;

  // Half-LSB of the discarded field; added before the shift for round-half-up.
  function automatic longint rnd_const(input int shift);
    return longint'(1) << (shift - 1);
  endfunction

  function automatic longint sat_max(input int owl);
    return (longint'(1) << (owl - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int owl);
    return -(longint'(1) << (owl - 1));
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO with a registered head entry (no fall-through).
// clr flushes the contents and takes priority over push and pop.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int WL    = FIR_OWL,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WL-1:0]              wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       rvalid,
  output logic [WL-1:0]              rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WL-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nxt;
  logic [LW-1:0] cnt_after_pop;
  logic [WL-1:0] head_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = cnt;

  always_comb begin
    rd_nxt        = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_after_pop = do_pop ? cnt - LW'(1) : cnt;
    cnt_nxt       = cnt;
    if (do_push && !do_pop)
      cnt_nxt = cnt + LW'(1);
    else if (!do_push && do_pop)
      cnt_nxt = cnt - LW'(1);
    // The entry being written becomes the head only when nothing else remains.
    head_nxt = (do_push && cnt_after_pop == '0) ? wdata : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      rvalid <= (cnt_nxt != '0);
      if (cnt_nxt != '0)
        rdata <= head_nxt;
    end
  end

endmodule

// File: rtl/fir_out_decimator.sv
// Decimates the FIR output stream, rounds/narrows kept samples and queues them.
// Define FIR_OUT_SAT_EN to clamp instead of wrap when narrowing to OWL bits.
module fir_out_decimator
  import fir_out_pkg::*;
#(
  parameter int WL    = FIR_WL,
  parameter int OWL   = FIR_OWL,
  parameter int SHIFT = 4,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [WL-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OWL-1:0]       out_data,
  output logic                        ovf,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [WL:0] RND_C = (WL + 1)'(rnd_const(SHIFT));
`ifdef FIR_OUT_SAT_EN
  localparam logic signed [WL:0] SAT_HI = (WL + 1)'(sat_max(OWL));
  localparam logic signed [WL:0] SAT_LO = (WL + 1)'(sat_min(OWL));
`endif

  function automatic logic signed [WL:0] round_shift(input logic signed [WL-1:0] x);
    logic signed [WL:0] xe;
    xe = {x[WL-1], x};
    return (xe + RND_C) >>> SHIFT;
  endfunction

  function automatic logic signed [OWL-1:0] narrow(input logic signed [WL:0] r);
`ifdef FIR_OUT_SAT_EN
    if (r > SAT_HI)
      return SAT_HI[OWL-1:0];
    else if (r < SAT_LO)
      return SAT_LO[OWL-1:0];
    else
      return r[OWL-1:0];
`else
    return r[OWL-1:0];
`endif
  endfunction

  logic [PW-1:0]          phase_q;
  logic                   vld_p0;
  logic signed [OWL-1:0]  data_p0;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [OWL-1:0]         fifo_rdata;

  // Stage p0: decimation select and round/narrow, pushed into the FIFO this cycle.
  assign vld_p0  = in_valid && !clr && (phase_q == '0);
  assign data_p0 = narrow(round_shift(in_data));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      phase_q <= '0;
    else if (clr)
      phase_q <= '0;
    else if (in_valid)
      phase_q <= (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf <= 1'b0;
    else if (clr)
      ovf <= 1'b0;
    else if (vld_p0 && fifo_full && !(out_ready && !fifo_empty))
      ovf <= 1'b1;
  end

  // Stage p1: registered FIFO head drives the consumer handshake.
  fir_out_fifo #(
    .WL    (OWL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .push   (vld_p0),
    .wdata  (data_p0),
    .pop    (out_ready),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level),
    .rvalid (out_valid),
    .rdata  (fifo_rdata)
  );

  assign out_data = fifo_rdata;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Self-checking bench for fir_out_decimator: vector table, corner sequences, random run.
module tb_fir_out_decimator;

  localparam int WL    = 32;
  localparam int OWL   = 16;
  localparam int SHIFT = 4;
  localparam int DECIM = 2;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr;
  logic                   in_valid;
  logic signed [WL-1:0]   in_data;
  logic                   out_ready;
  logic                   out_valid;
  logic signed [OWL-1:0]  out_data;
  logic                   ovf;
  logic [2:0]             level;
  logic                   out_ready1;
  logic                   out_valid1;
  logic signed [OWL-1:0]  out_data1;
  logic                   ovf1;
  logic [2:0]             level1;

  int total = 0;
  int bad   = 0;

  longint mq[$];
  int     mcnt;
  bit     movf;

  always #5 clk = ~clk;

  fir_out_decimator #(.WL(WL), .OWL(OWL), .SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .level(level)
  );

  fir_out_decimator #(.WL(WL), .OWL(OWL), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .ovf(ovf1), .level(level1)
  );

  typedef struct {
    string               nm;
    logic signed [31:0]  din;
    longint              e_wrap;
    longint              e_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Reference: floor((x + 2^(S-1)) / 2^S), then clamp or wrap to OWL bits.
  function automatic longint exp_out(input longint x);
    longint s, d, r;
    d = longint'(1) << SHIFT;
    s = x + (d / 2);
    r = (s >= 0) ? s / d : -((-s + d - 1) / d);
`ifdef FIR_OUT_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = r & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    return r;
  endfunction

  task automatic model_cycle(input bit c, input bit v, input longint d, input bit rdy);
    bit keep, fullb, popd;
    if (c) begin
      mq.delete();
      mcnt = 0;
      movf = 1'b0;
      return;
    end
    keep = v && (mcnt % DECIM == 0);
    if (v) mcnt++;
    fullb = (mq.size() == DEPTH);
    popd  = rdy && (mq.size() > 0);
    if (popd) void'(mq.pop_front());
    if (keep) begin
      if (!fullb || popd) mq.push_back(exp_out(d));
      else movf = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint e;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);
    step(); step();
    rst = 1'b1;
    step();

    tbl[0] = '{"round_p8",   32'sd8,          1,  1};
    tbl[1] = '{"round_p7",   32'sd7,          0,  0};
    tbl[2] = '{"round_m8",   -32'sd8,         0,  0};
    tbl[3] = '{"round_m9",   -32'sd9,        -1, -1};
    tbl[4] = '{"range_big",  32'h00100000,    0,  32767};
    tbl[5] = '{"range_max",  32'h7FFFFFFF,    0,  32767};
    tbl[6] = '{"range_min",  32'h80000000,    0, -32768};
    tbl[7] = '{"round_p24",  32'sd24,         2,  2};

    for (int i = 0; i < 8; i++) begin
      do_clr();
`ifdef FIR_OUT_SAT_EN
      e = tbl[i].e_sat;
`else
      e = tbl[i].e_wrap;
`endif
      in_valid = 1'b1; in_data = tbl[i].din; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk({tbl[i].nm, "_valid"}, out_valid, 1);
      chk(tbl[i].nm, out_data, e);
      step();
    end

    // Decimate by 2 with a always-ready consumer.
    do_clr();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 24;  step(); chk("dec_v0", out_valid, 1); chk("dec_d0", out_data, 2);
    in_data = 100; step(); chk("dec_v1", out_valid, 0); chk("dec_hold", out_data, 2);
    in_data = -24; step(); chk("dec_v2", out_valid, 1); chk("dec_d2", out_data, -1);
    in_data = 7;   step(); chk("dec_v3", out_valid, 0);
    in_valid = 1'b0; out_ready = 1'b0;

    // Overflow on the keep-everything instance.
    do_clr();
    out_ready1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 16 * i;
      step();
      if (i == 4) begin
        chk("ovf_lvl4", level1, 4);
        chk("ovf_not_yet", ovf1, 0);
      end
    end
    in_valid = 1'b0;
    chk("ovf_lvl", level1, 4);
    chk("ovf_set", ovf1, 1);
    chk("ovf_head", out_data1, 1);
    out_ready1 = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("ovf_pop_v", out_valid1, 1);
      chk("ovf_pop_d", out_data1, k);
    end
    step();
    chk("ovf_drain_v", out_valid1, 0);
    chk("ovf_sticky", ovf1, 1);
    chk("ovf_drain_lvl", level1, 0);
    out_ready1 = 1'b0;

    // Full FIFO with simultaneous push and pop.
    do_clr();
    chk("clr_ovf1", ovf1, 0);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 16 * i;
      step();
    end
    in_data = 80; out_ready1 = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fpp_lvl", level1, 4);
    chk("fpp_ovf", ovf1, 0);
    chk("fpp_head", out_data1, 2);
    for (int k = 3; k <= 5; k++) begin
      step();
      chk("fpp_order", out_data1, k);
    end
    step();
    chk("fpp_empty", out_valid1, 0);
    out_ready1 = 1'b0;

    // clr with level 3 and phase 1.
    do_clr();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 16 * i;
      step();
    end
    chk("clr_pre_lvl", level, 3);
    clr = 1'b1; in_valid = 1'b1; in_data = 999;
    step();
    clr = 1'b0;
    chk("clr_lvl", level, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_ovf", ovf, 0);
    in_data = 48;
    step();
    in_valid = 1'b0;
    chk("clr_keep_v", out_valid, 1);
    chk("clr_keep_d", out_data, 3);
    chk("clr_keep_lvl", level, 1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_level", level, 0);
    chk("arst_level1", level1, 0);
    step();
    rst = 1'b1;
    step();

    // Randomised run against the queue model.
    do_clr();
    model_cycle(1'b1, 1'b0, 0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 1) == 1)
        in_data = $urandom;
      else
        in_data = $signed($urandom_range(0, 2000)) - 1000;
      model_cycle(clr, in_valid, longint'(in_data), out_ready);
      step();
      chk("rnd_valid", out_valid, (mq.size() > 0));
      chk("rnd_level", level, mq.size());
      chk("rnd_ovf", ovf, movf);
      if (out_valid && mq.size() > 0)
        chk("rnd_data", out_data, mq[0]);
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
